add64_seq_ctrl: RTL and testbench
=================================

// Module: add64_seq_ctrl
// PURPOSE
//   Two-pass 64-bit add/subtract sequencer that sits directly upstream of, and consumes,
//   the 32-bit hybrid adder (CLA low half, Kogge-Stone high half).
//   - Accepts 64-bit operand pairs on a valid/ready interface.
//   - Drives the external combinational 32-bit adder twice: low half first, then high half
//     with the captured carry.
//   - Registers the 64-bit result, carry-out and signed overflow, and presents them on a
//     valid/ready output.
// PARAMETERS
//   HW      32   half-word width; must match the attached adder width; operands are 2*HW
//   SUB_EN  1    1: op_sub input honoured; 0: op_sub ignored (add only)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      operand pair present
//   in_ready    out  1      block can accept operands this cycle
//   in_a        in   2*HW   operand A
//   in_b        in   2*HW   operand B
//   in_cin      in   1      carry-in (add only; ignored when op_sub=1)
//   op_sub      in   1      1: compute A-B
//   adder_a     out  HW     to adder a
//   adder_b     out  HW     to adder b
//   adder_cin   out  1      to adder cin
//   adder_sum   in   HW     from adder sum (combinational, same cycle)
//   adder_cout  in   1      from adder cout (combinational, same cycle)
//   out_valid   out  1      result present
//   out_ready   in   1      consumer takes result
//   out_sum     out  2*HW   result
//   out_cout    out  1      carry-out; for subtract, 1 = no borrow
//   out_ovf     out  1      signed two's-complement overflow
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
//   - Reset: state=IDLE; operand regs, out_sum, out_cout, out_ovf, out_valid all 0.
//     - Reset asserted mid-operation aborts it; the op is discarded, never output.
//   - FSM states: IDLE, LO, HI, DONE.
//     - IDLE: in_ready=1. in_valid=1 latches A, B' and C0, then goes to LO.
//       - B' = op_sub ? ~in_b : in_b
//       - C0 = op_sub ? 1 : in_cin
//     - LO: adder_a=A[HW-1:0], adder_b=B'[HW-1:0], adder_cin=C0.
//       At the edge: sum_lo<=adder_sum, c_mid<=adder_cout; go to HI.
//     - HI: adder_a=A[2HW-1:HW], adder_b=B'[2HW-1:HW], adder_cin=c_mid.
//       At the edge: out_sum<={adder_sum,sum_lo}, out_cout<=adder_cout,
//       out_ovf<=(A[2HW-1]~^B'[2HW-1]) & (adder_sum[HW-1]^A[2HW-1]); go to DONE.
//     - DONE: out_valid=1; outputs held stable until out_ready=1.
//       - out_ready=1 and in_valid=0: go to IDLE.
//       - out_ready=1 and in_valid=1: accept the new op in the same cycle
//         (in_ready=out_ready in DONE) and go to LO. Back-to-back throughput is 1 op / 3 cycles.
//   - adder_a, adder_b and adder_cin are 0 in IDLE and DONE.
//   - Latency: accept edge to out_valid=1 is 2 clocks.
//   - The transfer handshake fires only when valid&ready on the same edge.
//     in_* values are sampled only on that edge.
//   - out_sum, out_cout and out_ovf keep their last value after the result transfer;
//     they change only at HI capture or reset.
//   - SUB_EN=0: op_sub is treated as 0.
//   - Width: all arithmetic is modulo 2^(2*HW); no internal adder (the external one is used).
// TESTING
//   - Carry across halves: A=0x0000_0000_FFFF_FFFF, B=1, cin=0 -> sum=0x0000_0001_0000_0000,
//     cout=0, ovf=0; out_valid 2 clocks after accept.
//   - Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> sum=0, cout=1, ovf=0.
//   - Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
//   - Subtract with borrow: op_sub=1, A=5, B=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//     Same inputs with A=7, B=5 -> sum=2, cout=1.
//   - Backpressure: out_ready=0 for 5 clocks in DONE -> out_* stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> new op accepted on the same edge.
//   - Reset mid-op: rst_n low during HI -> all outputs 0 immediately, with no clock.
//     After release: in_ready=1, no spurious out_valid.

Source files
------------

// File: rtl/add64_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : add64_seq_ctrl
//  Description : Two-pass 2*HW-bit add/subtract sequencer. Drives an external
//                combinational HW-bit adder twice (low half, then high half
//                with the captured carry) and registers the full result,
//                carry-out and signed overflow behind a valid/ready output.
//  Revision    : 1.0  - initial release
// ============================================================================
module add64_seq_ctrl #(
    parameter int HW     = 32,
    parameter bit SUB_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    // operand side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*HW-1:0] in_a,
    input  logic [2*HW-1:0] in_b,
    input  logic            in_cin,
    input  logic            op_sub,
    // external half-width adder
    output logic [HW-1:0]   adder_a,
    output logic [HW-1:0]   adder_b,
    output logic            adder_cin,
    input  logic [HW-1:0]   adder_sum,
    input  logic            adder_cout,
    // result side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*HW-1:0] out_sum,
    output logic            out_cout,
    output logic            out_ovf
);

    localparam int W = 2 * HW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a;        // operand A
    logic [W-1:0]    r_b;        // B' (already inverted for subtract)
    logic            r_c0;       // carry into the low half
    logic [HW-1:0]   r_sum_lo;   // low half of the result
    logic            r_c_mid;    // carry from low half into high half
    logic [W-1:0]    r_out_sum;
    logic            r_out_cout;
    logic            r_out_ovf;

    logic            w_sub;
    logic            w_accept;

    // Subtract is only honoured when the build enables it
    assign w_sub    = SUB_EN ? op_sub : 1'b0;
    assign w_accept = in_valid & in_ready;

    assign out_valid = (r_state == S_DONE);
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state adder steering
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        adder_a     = '0;
        adder_b     = '0;
        adder_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                adder_a     = r_a[HW-1:0];
                adder_b     = r_b[HW-1:0];
                adder_cin   = r_c0;
                w_state_nxt = S_HI;
            end
            S_HI: begin
                adder_a     = r_a[W-1:HW];
                adder_b     = r_b[W-1:HW];
                adder_cin   = r_c_mid;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // A result transfer frees the slot for a new op on the same edge
                in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? S_LO : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept; subtract folds into B' and a forced carry-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c0 <= 1'b0;
        end else if (w_accept) begin
            r_a  <= in_a;
            r_b  <= w_sub ? ~in_b : in_b;
            r_c0 <= w_sub ? 1'b1 : in_cin;
        end
    end

    // Low-half result and inter-half carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_lo <= '0;
            r_c_mid  <= 1'b0;
        end else if (r_state == S_LO) begin
            r_sum_lo <= adder_sum;
            r_c_mid  <= adder_cout;
        end
    end

    // Final result capture; held unchanged until the next high-half pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else if (r_state == S_HI) begin
            r_out_sum  <= {adder_sum, r_sum_lo};
            r_out_cout <= adder_cout;
            r_out_ovf  <= (r_a[W-1] ~^ r_b[W-1]) & (adder_sum[HW-1] ^ r_a[W-1]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add64_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add64_seq_ctrl
//  Description : Self-checking bench for add64_seq_ctrl with a behavioural
//                32-bit adder and an arithmetic reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_add64_seq_ctrl;

    localparam int HW = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2*HW-1:0] in_a;
    logic [2*HW-1:0] in_b;
    logic            in_cin;
    logic            op_sub;
    logic [HW-1:0]   adder_a;
    logic [HW-1:0]   adder_b;
    logic            adder_cin;
    logic [HW-1:0]   adder_sum;
    logic            adder_cout;
    logic            out_valid;
    logic            out_ready;
    logic [2*HW-1:0] out_sum;
    logic            out_cout;
    logic            out_ovf;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic signed [65:0] MAXS = 66'sd9223372036854775807;
    localparam logic signed [65:0] MINS = -66'sd9223372036854775808;

    add64_seq_ctrl #(.HW(HW), .SUB_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .op_sub     (op_sub),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf)
    );

    // External combinational half-width adder
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{HW{1'b0}}, adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: plain unsigned and signed arithmetic on the full operands
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub, output logic [63:0] s, output logic co,
                         output logic ov);
        logic [64:0]        u;
        logic signed [65:0] r;
        r = $signed({{2{a[63]}}, a});
        if (sub) begin
            u  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            r  = r - $signed({{2{b[63]}}, b});
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            co = u[64];
            r  = r + $signed({{2{b[63]}}, b});
            if (cin) r = r + 66'sd1;
        end
        s  = u[63:0];
        ov = (r > MAXS) || (r < MINS);
    endtask

    // Present one op and let it be accepted on the next rising edge
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sub);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        op_sub   = sub;
        #1;
        chk("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge: they must not be resampled
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_cin   = 1'($urandom);
        op_sub   = 1'($urandom);
    endtask

    // Wait (bounded) for out_valid, check latency and result fields
    task automatic wait_check(input string tag, input logic [63:0] es, input logic ec,
                              input logic eo);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd2);
        chk({tag, "_sum"},  out_sum, es);
        chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
        chk({tag, "_ovf"},  {63'd0, out_ovf},  {63'd0, eo});
    endtask

    // Full op with out_ready high: result transfers on the edge after DONE
    task automatic op_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub, input logic [63:0] es,
                            input logic ec, input logic eo);
        issue(a, b, cin, sub);
        wait_check(tag, es, ec, eo);
        @(posedge clk);
        #1;
        chk({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_hold"}, out_sum, es);
    endtask

    initial begin
        logic [63:0] a, b, s, hold;
        logic        cin, sub, co, ov;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_sum",   out_sum, 64'd0);
        chk("rst_cout_ovf",  {62'd0, out_cout, out_ovf}, 64'd0);
        chk("rst_adder_a",   {32'd0, adder_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic corners
        op_check("carry_mid", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        op_check("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'd0, 1'b1, 1'b0);
        op_check("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        op_check("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        op_check("sub_noborrow", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
        op_check("cin_add", 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1, 1'b0,
                 64'h0000_0001_0000_0000, 1'b0, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom);
            sub = 1'($urandom);
            if (i % 4 == 1) a[31:0] = 32'hFFFF_FFFF;
            if (i % 4 == 2) b = ~a;
            model(a, b, cin, sub, s, co, ov);
            op_check("rand", a, b, cin, sub, s, co, ov);
        end

        // Backpressure: hold DONE for 5 clocks, then accept on the transfer edge
        out_ready = 1'b0;
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h0FED_CBA9_8765_4321;
        model(a, b, 1'b0, 1'b0, s, co, ov);
        issue(a, b, 1'b0, 1'b0);
        wait_check("bp_first", s, co, ov);
        hold = s;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_sum_stable", out_sum, hold);
        end
        out_ready = 1'b1;
        a = 64'h8000_0000_0000_0000;
        b = 64'd1;
        model(a, b, 1'b0, 1'b1, s, co, ov);
        issue(a, b, 1'b0, 1'b1);
        chk("bp_next_accepted", {63'd0, out_valid}, 64'd0);
        wait_check("bp_second", s, co, ov);
        @(posedge clk);
        #1;

        // Reset during the high-half pass
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum",   out_sum, 64'd0);
        chk("midrst_flags", {61'd0, out_valid, out_cout, out_ovf}, 64'd0);
        chk("midrst_adder", {31'd0, adder_cin, adder_a}, 64'd0);
        chk("midrst_adder_b", {32'd0, adder_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_valid", {63'd0, out_valid}, 64'd0);
            chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
        end

        // Recovery op after the abort
        a = 64'h0000_0001_0000_0000;
        b = 64'd1;
        model(a, b, 1'b0, 1'b1, s, co, ov);
        op_check("after_rst", a, b, 1'b0, 1'b1, s, co, ov);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
